datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 202 ++++++++++++++++++++
 tb/tb_datapath.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Processor datapath: holds PC, IR, a four-entry register file and the ALU flags.
// It decodes IR for the control unit and produces the RAM address and write data.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNEG   = 4'd3,
    I_BNZERO = 4'd4,
    I_BNNEG  = 4'd5,
    I_LOAD   = 4'd6,
    I_STORE  = 4'd7,
    I_MOVE   = 4'd8,
    I_ADD    = 4'd9,
    I_SUB    = 4'd10,
    I_AND    = 4'd11,
    I_OR     = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;
endpackage

module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out
);

  logic [ADDR_W-1:0]       pc_r;
  logic [DATA_W-1:0]       ir_r;
  logic [DATA_W-1:0]       regs_r [4];
  logic                    zero_r;
  logic                    neg_r;
  logic                    uov_r;
  logic                    sov_r;

  decoded_instruction_type decoded_s;
  logic [1:0]              sel_a_s;
  logic [1:0]              sel_b_s;
  logic [1:0]              sel_c_s;
  logic [DATA_W-1:0]       op_a_s;
  logic [DATA_W-1:0]       op_b_s;
  logic [DATA_W:0]         alu_full_s;
  logic [DATA_W-1:0]       alu_result_s;
  logic                    alu_uov_s;
  logic                    alu_sov_s;
  logic [DATA_W-1:0]       wb_data_s;
  logic                    unused_ir_s;

  // Opcode decode of the current IR
  always_comb begin
    decoded_s = I_NOP;
    case (ir_r[15:8])
      8'h00:   decoded_s = I_NOP;
      8'h01:   decoded_s = I_BRANCH;
      8'h02:   decoded_s = I_BZERO;
      8'h03:   decoded_s = I_BNEG;
      8'h0A:   decoded_s = I_BNZERO;
      8'h0B:   decoded_s = I_BNNEG;
      8'h81:   decoded_s = I_LOAD;
      8'h82:   decoded_s = I_STORE;
      8'h91:   decoded_s = I_MOVE;
      8'hA1:   decoded_s = I_ADD;
      8'hA2:   decoded_s = I_SUB;
      8'hA3:   decoded_s = I_AND;
      8'hA4:   decoded_s = I_OR;
      8'hFF:   decoded_s = I_HALT;
      default: decoded_s = I_NOP;
    endcase
  end

  // Register field selection; MOVE reuses the ALU with A=B so OR passes B through
  always_comb begin
    sel_a_s = ir_r[3:2];
    sel_b_s = ir_r[1:0];
    sel_c_s = ir_r[5:4];
    case (decoded_s)
      I_MOVE: begin
        sel_a_s = ir_r[1:0];
        sel_c_s = ir_r[3:2];
      end
      I_LOAD, I_STORE: sel_c_s = ir_r[6:5];
      default:         sel_c_s = ir_r[5:4];
    endcase
  end

  assign op_a_s = regs_r[sel_a_s];
  assign op_b_s = regs_r[sel_b_s];

  // ALU with carry/borrow in the extra top bit
  always_comb begin
    alu_full_s = {(DATA_W+1){1'b0}};
    alu_uov_s  = 1'b0;
    alu_sov_s  = 1'b0;
    case (operation)
      2'b00: alu_full_s = {1'b0, op_a_s | op_b_s};
      2'b01: begin
        alu_full_s = {1'b0, op_a_s} + {1'b0, op_b_s};
        alu_uov_s  = alu_full_s[DATA_W];
        alu_sov_s  = (op_a_s[DATA_W-1] == op_b_s[DATA_W-1]) &&
                     (alu_full_s[DATA_W-1] != op_a_s[DATA_W-1]);
      end
      2'b10: begin
        alu_full_s = {1'b0, op_a_s} - {1'b0, op_b_s};
        alu_uov_s  = alu_full_s[DATA_W];
        alu_sov_s  = (op_a_s[DATA_W-1] != op_b_s[DATA_W-1]) &&
                     (alu_full_s[DATA_W-1] != op_a_s[DATA_W-1]);
      end
      2'b11:   alu_full_s = {1'b0, op_a_s & op_b_s};
      default: alu_full_s = {(DATA_W+1){1'b0}};
    endcase
  end

  assign alu_result_s = alu_full_s[DATA_W-1:0];
  assign wb_data_s    = c_sel ? data_in : alu_result_s;
  assign unused_ir_s  = ir_r[7];

  // Program counter: branch target from the pre-edge IR, else wrap-around increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= {ADDR_W{1'b0}};
    end else if (pc_enable) begin
      if (branch) begin
        pc_r <= ir_r[ADDR_W-1:0];
      end else begin
        pc_r <= pc_r + ADDR_W'(1);
      end
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_r <= {DATA_W{1'b0}};
    end else if (ir_enable) begin
      ir_r <= data_in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Register file write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (write_reg_enable) begin
      regs_r[sel_c_s] <= wb_data_s;
    end
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
      uov_r  <= 1'b0;
      sov_r  <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_r <= (alu_result_s == {DATA_W{1'b0}});
      neg_r  <= alu_result_s[DATA_W-1];
      uov_r  <= alu_uov_s;
      sov_r  <= alu_sov_s;
    end else begin
      zero_r <= zero_r;
      neg_r  <= neg_r;
      uov_r  <= uov_r;
      sov_r  <= sov_r;
    end
  end

  assign decoded_instruction = decoded_s;
  assign zero_op             = zero_r;
  assign neg_op              = neg_r;
  assign unsigned_overflow   = uov_r;
  assign signed_overflow     = sov_r;
  assign ram_addr            = addr_sel ? pc_r : ir_r[ADDR_W-1:0];
  assign data_out            = regs_r[ir_r[6:5]];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios plus random control/data traffic,
// all compared against an arithmetic reference model of the architectural state.
module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic        write_reg_enable, flags_reg_enable;
  logic [1:0]  operation;
  logic [15:0] data_in, data_out;
  logic [4:0]  ram_addr;
  logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
  decoded_instruction_type decoded_instruction;

  datapath #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr),
    .data_in(data_in), .data_out(data_out)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference architectural state
  int          m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_r [4];
  bit          m_z, m_n, m_u, m_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic decoded_instruction_type m_decode(input logic [15:0] ir);
    case (ir[15:8])
      8'h01: return I_BRANCH;
      8'h02: return I_BZERO;
      8'h03: return I_BNEG;
      8'h0A: return I_BNZERO;
      8'h0B: return I_BNNEG;
      8'h81: return I_LOAD;
      8'h82: return I_STORE;
      8'h91: return I_MOVE;
      8'hA1: return I_ADD;
      8'hA2: return I_SUB;
      8'hA3: return I_AND;
      8'hA4: return I_OR;
      8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  task automatic idle();
    branch = 1'b0; pc_enable = 1'b0; ir_enable = 1'b0; c_sel = 1'b0;
    write_reg_enable = 1'b0; flags_reg_enable = 1'b0; operation = 2'b00;
  endtask

  // compare outputs against the model, then clock one edge and advance the model
  task automatic tick();
    decoded_instruction_type d;
    int ai, bi, ci, ua, ub, res, sa, sb, sres;
    bit u, s;
    #1;
    check("ram_addr", 32'(ram_addr), addr_sel ? 32'(m_pc) : 32'(m_ir[4:0]));
    check("data_out", 32'(data_out), 32'(m_r[m_ir[6:5]]));
    check("decode", 32'(decoded_instruction), 32'(m_decode(m_ir)));
    check("zero", 32'(zero_op), 32'(m_z));
    check("neg", 32'(neg_op), 32'(m_n));
    check("uovf", 32'(unsigned_overflow), 32'(m_u));
    check("sovf", 32'(signed_overflow), 32'(m_s));
    d = m_decode(m_ir);
    ai = m_ir[3:2]; bi = m_ir[1:0]; ci = m_ir[5:4];
    if (d == I_MOVE) begin ai = m_ir[1:0]; ci = m_ir[3:2]; end
    if (d == I_LOAD || d == I_STORE) ci = m_ir[6:5];
    ua = m_r[ai]; ub = m_r[bi];
    sa = int'($signed(m_r[ai])); sb = int'($signed(m_r[bi]));
    u = 1'b0; s = 1'b0;
    case (operation)
      2'b00: res = ua | ub;
      2'b01: begin res = ua + ub; u = (res > 65535); sres = sa + sb; s = (sres > 32767) || (sres < -32768); end
      2'b10: begin res = ua - ub; u = (ua < ub); sres = sa - sb; s = (sres > 32767) || (sres < -32768); end
      default: res = ua & ub;
    endcase
    res = res & 32'hFFFF;
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 0; m_ir = 16'h0000;
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_z = 1'b0; m_n = 1'b0; m_u = 1'b0; m_s = 1'b0;
    end else begin
      if (write_reg_enable) m_r[ci] = c_sel ? data_in : res[15:0];
      if (flags_reg_enable) begin
        m_z = (res == 0); m_n = res[15]; m_u = u; m_s = s;
      end
      if (pc_enable) m_pc = branch ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
      if (ir_enable) m_ir = data_in;
    end
    @(negedge clk);
  endtask

  task automatic load_ir(input logic [15:0] v);
    idle(); data_in = v; ir_enable = 1'b1; tick(); idle();
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [15:0] v);
    logic [15:0] instr;
    instr = 16'h8100 | (16'(idx) << 5);
    load_ir(instr);
    data_in = v; c_sel = 1'b1; write_reg_enable = 1'b1; tick(); idle();
  endtask

  logic [7:0] op_list [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h81,
                               8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};

  initial begin
    logic [7:0]  lo, opc;
    logic [15:0] instr;
    idle(); rst_n = 1'b0; addr_sel = 1'b1; data_in = 16'h0000;
    m_pc = 0; m_ir = 16'h0000; m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_decode", 32'(decoded_instruction), 32'(I_NOP));

    // fetch and increment
    load_ir(16'hA11B);
    pc_enable = 1'b1; tick(); idle();
    #1;
    check("fetch_decode", 32'(decoded_instruction), 32'(I_ADD));
    check("fetch_pc", 32'(ram_addr), 32'd1);

    // walk PC to 31, wrap, then branch
    pc_enable = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    idle(); #1;
    check("pc_31", 32'(ram_addr), 32'd31);
    pc_enable = 1'b1; tick(); idle(); #1;
    check("pc_wrap", 32'(ram_addr), 32'd0);
    load_ir(16'h0114);
    pc_enable = 1'b1; branch = 1'b1; tick(); idle(); #1;
    check("branch_pc", 32'(ram_addr), 32'd20);

    // ADD signed overflow
    load_reg(2'd2, 16'h7FFF);
    load_reg(2'd3, 16'h0001);
    load_ir(16'hA11B);
    operation = 2'b01; write_reg_enable = 1'b1; flags_reg_enable = 1'b1; tick(); idle(); #1;
    check("add_neg", 32'(neg_op), 32'd1);
    check("add_sovf", 32'(signed_overflow), 32'd1);
    check("add_uovf", 32'(unsigned_overflow), 32'd0);
    check("add_zero", 32'(zero_op), 32'd0);
    load_ir(16'h0020); #1;
    check("add_r1", 32'(data_out), 32'h8000);

    // SUB equal operands, then borrow
    load_reg(2'd0, 16'd5);
    load_reg(2'd1, 16'd5);
    load_ir(16'hA221);
    operation = 2'b10; write_reg_enable = 1'b1; flags_reg_enable = 1'b1; tick(); idle(); #1;
    check("sub_zero", 32'(zero_op), 32'd1);
    check("sub_nobrw", 32'(unsigned_overflow), 32'd0);
    load_reg(2'd1, 16'd6);
    load_ir(16'hA221);
    operation = 2'b10; write_reg_enable = 1'b1; flags_reg_enable = 1'b1; tick(); idle(); #1;
    check("sub_borrow", 32'(unsigned_overflow), 32'd1);
    check("sub_neg", 32'(neg_op), 32'd1);
    load_ir(16'h0040); #1;
    check("sub_r2", 32'(data_out), 32'hFFFF);

    // LOAD / STORE addressing
    load_ir(16'h8145);
    addr_sel = 1'b0; #1;
    check("ld_addr", 32'(ram_addr), 32'd5);
    data_in = 16'h1234; c_sel = 1'b1; write_reg_enable = 1'b1; tick(); idle();
    load_ir(16'h8245); #1;
    check("st_data", 32'(data_out), 32'h1234);

    // reset with every enable active
    rst_n = 1'b0; branch = 1'b1; pc_enable = 1'b1; ir_enable = 1'b1; c_sel = 1'b1;
    write_reg_enable = 1'b1; flags_reg_enable = 1'b1; operation = 2'b01; data_in = 16'hA1FF;
    tick(); idle(); rst_n = 1'b1; addr_sel = 1'b1; #1;
    check("mrst_decode", 32'(decoded_instruction), 32'(I_NOP));
    check("mrst_addr", 32'(ram_addr), 32'd0);
    check("mrst_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      instr = 16'(i) << 5;
      load_ir(instr); #1;
      check("mrst_reg", 32'(data_out), 32'd0);
    end
    load_ir(16'h5500); #1;
    check("unknown_op", 32'(decoded_instruction), 32'(I_NOP));

    // random traffic
    for (int n = 0; n < 600; n++) begin
      lo  = 8'($urandom());
      opc = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : op_list[$urandom_range(0, 13)];
      data_in = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : {opc, lo};
      rst_n = ($urandom_range(0, 40) != 0);
      branch = 1'($urandom()); pc_enable = 1'($urandom()); ir_enable = 1'($urandom());
      addr_sel = 1'($urandom()); c_sel = 1'($urandom()); operation = 2'($urandom());
      write_reg_enable = 1'($urandom()); flags_reg_enable = 1'($urandom());
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
